sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port between NUM_REQ requesters, e.g. N64 PI, USB/CPU bridge and SD DMA.
- Round-robin arbitration, exactly one outstanding transaction at a time.
- Sits directly upstream of the sdram controller and presents the same request/write/busy/ack handshake on both sides.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 25, byte address width; matches the controller.
- DATA_W, 32, data width.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_request  in  NUM_REQ  per-requester request; held until o_ack.
- i_write  in  NUM_REQ  per-requester write flag; 1 = write.
- i_address  in  NUM_REQ*ADDR_W  packed addresses; requester n uses bits [n*ADDR_W +: ADDR_W].
- i_data  in  NUM_REQ*DATA_W  packed write data.
- o_busy  out  NUM_REQ  requester n's transaction is in flight.
- o_ack  out  NUM_REQ  one-cycle completion pulse.
- o_data  out  DATA_W  read data; valid in the o_ack cycle, shared by all requesters.
- o_mem_request  out  1  to controller i_request.
- o_mem_write  out  1  to controller i_write.
- i_mem_busy  in  1  from controller o_busy.
- i_mem_ack  in  1  from controller o_ack.
- o_mem_address  out  ADDR_W  to controller i_address.
- o_mem_data  out  DATA_W  to controller i_data.
- i_mem_data  in  DATA_W  from controller o_data.

Behaviour:
- All outputs are registered.
- Reset values:
  - o_busy = 0, o_ack = 0, o_data = 0.
  - o_mem_request = 0, o_mem_write = 0, o_mem_address = 0, o_mem_data = 0.
  - State IDLE; last-grant pointer = NUM_REQ-1, so requester 0 wins first.
- Reset mid-transaction drops everything immediately. No ack is issued. A late i_mem_ack arriving after reset, while in IDLE, is ignored.
- FSM states: IDLE, ISSUE, WAIT_ACK.
- IDLE:
  - Eligible requesters are those with i_request[n]=1 and o_ack[n]=0 in the current cycle. A requester still holding request in its ack cycle is therefore not re-granted.
  - Winner = first eligible index searching upward from last_grant+1, modulo NUM_REQ.
  - If a winner exists:
    - Latch its address, write flag and data into o_mem_*.
    - grant <= winner, last_grant <= winner, o_busy[winner] <= 1, o_mem_request <= 1.
    - Go to ISSUE.
  - Grant latency: request high at cycle t → o_mem_request high at t+1.
- ISSUE:
  - Hold o_mem_request and the o_mem_* values stable.
  - When i_mem_busy=0 in a cycle with o_mem_request=1, the controller has accepted: o_mem_request <= 0, go to WAIT_ACK.
  - i_mem_busy may stay high for any number of cycles; there is no timeout.
- WAIT_ACK:
  - On i_mem_ack: o_data <= i_mem_data (also for writes; the value is don't-care), o_ack[grant] <= 1 for one cycle, o_busy[grant] <= 0, go to IDLE.
  - i_mem_ack arriving in the same cycle as acceptance is legal and is taken in WAIT_ACK's first cycle. Under no circumstances may an ack be lost.
- Only one o_ack bit is ever set at a time; o_busy is one-hot or zero.
- Minimum back-to-back spacing:
  - Ack at cycle t → next grant decided at t+1, o_mem_request at t+2.
  - A different requester that is already waiting gets o_mem_request at t+1, because the IDLE decision is made in the o_ack cycle.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,0,…; no requester waits more than NUM_REQ-1 transactions.
- Requester inputs (i_write, i_address, i_data) are sampled only at grant. Changes afterwards have no effect.
- A requester dropping i_request before grant is not served. Dropping it after grant does not cancel the transaction; o_ack still pulses.

Decomposition:
- sdram_arb_pkg holds: state enum (IDLE/ISSUE/WAIT_ACK), ADDR_W/DATA_W defaults, and the index-width function clog2(NUM_REQ).
- One sub-module: sdram_rr_picker.
  - Combinational.
  - Inputs: eligible mask, last_grant. Outputs: valid, winner index.
  - Reusable by other arbiters.

Test Plan:
- Single read: req0 addr 0x0001000; controller busy 3 cycles, ack with 0xDEADBEEF → o_mem_request at t+1 with addr 0x0001000, write=0; o_ack[0] one cycle later carrying o_data=0xDEADBEEF; o_busy[0] 1→0.
- Contention: req0, req1, req2 asserted together and held → grant order 0,1,2,0,1,2 across 6 transactions; o_busy and o_ack always one-hot.
- Ack-cycle hold: req1 keeps i_request high through its o_ack while req2 also requests → next grant goes to req2, never a duplicate to req1.
- Write data latch: req2 write addr 0x1FFFFFC data 0xA5A5A5A5; i_data changed during ISSUE → o_mem_data stays 0xA5A5A5A5 and o_mem_write=1 until acceptance.
- Same-cycle accept+ack: controller returns i_mem_busy=0 and i_mem_ack=1 in one cycle → exactly one o_ack pulse; FSM back in IDLE.
- Reset mid-transaction: i_reset in WAIT_ACK, then a stray i_mem_ack → all outputs 0, no o_ack; next req0 request is granted normally.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types, defaults and helpers for the SDRAM port arbiter and its
// round-robin picker.
package sdram_arb_pkg;

    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_ADDR_W  = 25;
    localparam int DEF_DATA_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } arb_state_e;

    // Bits needed to index n requesters, never less than one.
    function automatic int clog2(input int n);
        int w;
        w = 32'sd1;
        for (int i = 32'sd1; i < 32'sd31; i++) begin
            if ((32'sd1 << i) < n) begin
                w = i + 32'sd1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sdram_rr_picker.sv
// Combinational round-robin picker: first eligible index above last_grant,
// wrapping modulo NUM_REQ.
module sdram_rr_picker
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = clog2(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    logic [IDX_W-1:0] idx_s;

    // Scan from the farthest offset down so the nearest eligible index wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx_s  = '0;
        for (int off = NUM_REQ; off >= 32'sd1; off--) begin
            idx_s = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            if (eligible[idx_s]) begin
                valid  = 1'b1;
                winner = idx_s;
            end else begin
                valid  = valid;
                winner = winner;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between NUM_REQ
// requesters, one outstanding transaction at a time, all outputs registered.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_request,
    input  logic [NUM_REQ-1:0]        i_write,
    input  logic [NUM_REQ*ADDR_W-1:0] i_address,
    input  logic [NUM_REQ*DATA_W-1:0] i_data,
    output logic [NUM_REQ-1:0]        o_busy,
    output logic [NUM_REQ-1:0]        o_ack,
    output logic [DATA_W-1:0]         o_data,
    output logic                      o_mem_request,
    output logic                      o_mem_write,
    input  logic                      i_mem_busy,
    input  logic                      i_mem_ack,
    output logic [ADDR_W-1:0]         o_mem_address,
    output logic [DATA_W-1:0]         o_mem_data,
    input  logic [DATA_W-1:0]         i_mem_data
);

    localparam int               IDX_W     = clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    arb_state_e         state_r, state_nxt_s;
    logic [IDX_W-1:0]   grant_r, grant_nxt_s;
    logic [IDX_W-1:0]   last_grant_r, last_grant_nxt_s;
    logic               ack_pend_r, ack_pend_nxt_s;
    logic [NUM_REQ-1:0] busy_nxt_s, ack_nxt_s;
    logic [DATA_W-1:0]  data_nxt_s;
    logic               mem_request_nxt_s, mem_write_nxt_s;
    logic [ADDR_W-1:0]  mem_address_nxt_s;
    logic [DATA_W-1:0]  mem_data_nxt_s;
    logic [NUM_REQ-1:0] eligible_s;
    logic               pick_valid_s;
    logic [IDX_W-1:0]   pick_winner_s;
    logic [ADDR_W-1:0]  req_addr_s [NUM_REQ];
    logic [DATA_W-1:0]  req_data_s [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_addr_s[g] = i_address[g*ADDR_W +: ADDR_W];
        assign req_data_s[g] = i_data[g*DATA_W +: DATA_W];
    end

    // A requester still holding request during its own ack cycle must not be re-granted.
    assign eligible_s = i_request & ~o_ack;

    sdram_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .eligible   (eligible_s),
        .last_grant (last_grant_r),
        .valid      (pick_valid_s),
        .winner     (pick_winner_s)
    );

    // Next-state and next-output logic for the grant / issue / wait-ack sequence.
    always_comb begin
        state_nxt_s       = state_r;
        grant_nxt_s       = grant_r;
        last_grant_nxt_s  = last_grant_r;
        ack_pend_nxt_s    = ack_pend_r;
        busy_nxt_s        = o_busy;
        ack_nxt_s         = '0;
        data_nxt_s        = o_data;
        mem_request_nxt_s = o_mem_request;
        mem_write_nxt_s   = o_mem_write;
        mem_address_nxt_s = o_mem_address;
        mem_data_nxt_s    = o_mem_data;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    grant_nxt_s                = pick_winner_s;
                    last_grant_nxt_s           = pick_winner_s;
                    busy_nxt_s                 = '0;
                    busy_nxt_s[pick_winner_s]  = 1'b1;
                    mem_request_nxt_s          = 1'b1;
                    mem_write_nxt_s            = i_write[pick_winner_s];
                    mem_address_nxt_s          = req_addr_s[pick_winner_s];
                    mem_data_nxt_s             = req_data_s[pick_winner_s];
                    ack_pend_nxt_s             = 1'b0;
                    state_nxt_s                = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!i_mem_busy) begin
                    // An ack in the acceptance cycle is parked and delivered from WAIT_ACK.
                    mem_request_nxt_s = 1'b0;
                    ack_pend_nxt_s    = i_mem_ack;
                    if (i_mem_ack) begin
                        data_nxt_s = i_mem_data;
                    end else begin
                        data_nxt_s = o_data;
                    end
                    state_nxt_s = ST_WAIT_ACK;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_pend_r || i_mem_ack) begin
                    if (ack_pend_r) begin
                        data_nxt_s = o_data;
                    end else begin
                        data_nxt_s = i_mem_data;
                    end
                    ack_nxt_s[grant_r] = 1'b1;
                    busy_nxt_s         = '0;
                    ack_pend_nxt_s     = 1'b0;
                    state_nxt_s        = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_ACK;
                end
            end
            default: begin
                busy_nxt_s        = '0;
                mem_request_nxt_s = 1'b0;
                ack_pend_nxt_s    = 1'b0;
                state_nxt_s       = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r       <= ST_IDLE;
            grant_r       <= '0;
            last_grant_r  <= LAST_INIT;
            ack_pend_r    <= 1'b0;
            o_busy        <= '0;
            o_ack         <= '0;
            o_data        <= '0;
            o_mem_request <= 1'b0;
            o_mem_write   <= 1'b0;
            o_mem_address <= '0;
            o_mem_data    <= '0;
        end else begin
            state_r       <= state_nxt_s;
            grant_r       <= grant_nxt_s;
            last_grant_r  <= last_grant_nxt_s;
            ack_pend_r    <= ack_pend_nxt_s;
            o_busy        <= busy_nxt_s;
            o_ack         <= ack_nxt_s;
            o_data        <= data_nxt_s;
            o_mem_request <= mem_request_nxt_s;
            o_mem_write   <= mem_write_nxt_s;
            o_mem_address <= mem_address_nxt_s;
            o_mem_data    <= mem_data_nxt_s;
        end
    end

endmodule
